// File: rtl/song_scheduler.sv
// song_scheduler: scrolls a two-lane bongo song from a sync ROM past the
// hit detectors, clears scored notes and keeps a saturating score.
// Ports: clk, reset_b (async, active-low), start, pause, rom_addr/rom_data,
//   hit_l/hit_r in; stream_l/r, lane_l/r, step, score, busy, done out.
// Optional: define MISS_COUNT_EN to add the `misses` output (unscored notes).
module song_scheduler #(
   parameter int TICK_DIV = 12_500_000,
   parameter int SONG_LEN = 64,
   parameter int ADDR_W   = 6,
   parameter int LANE_LEN = 8,
   parameter int SCORE_W  = 10
) (
   input  logic                clk,
   input  logic                reset_b,
   input  logic                start,
   input  logic                pause,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [1:0]          rom_data,
   input  logic                hit_l,
   input  logic                hit_r,
   output logic [2:0]          stream_l,
   output logic [2:0]          stream_r,
   output logic [LANE_LEN-1:0] lane_l,
   output logic [LANE_LEN-1:0] lane_r,
   output logic                step,
   output logic [SCORE_W-1:0]  score,
`ifdef MISS_COUNT_EN
   output logic [SCORE_W-1:0]  misses,
`endif
   output logic                busy,
   output logic                done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW = (LANE_LEN > 1) ? $clog2(LANE_LEN) : 1;
   localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [FW-1:0]     FLUSH_LAST = FW'(LANE_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PLAY,
      FLUSH,
      DONE
   } state_t;

   state_t              state;
   logic [TW-1:0]       tick;
   logic [FW-1:0]       flush_cnt;

   logic                run;
   logic                hit_l_ok;
   logic                hit_r_ok;
   logic [LANE_LEN-1:0] lane_l_hit;
   logic [LANE_LEN-1:0] lane_r_hit;
   logic                tick_end;
   logic                note_l;
   logic                note_r;
   logic [1:0]          gain;
   logic [SCORE_W:0]    score_sum;
   logic [SCORE_W-1:0]  score_next;
`ifdef MISS_COUNT_EN
   logic [1:0]          miss_gain;
   logic [SCORE_W:0]    miss_sum;
   logic [SCORE_W-1:0]  miss_next;
`endif

   assign stream_l = lane_l[2:0];
   assign stream_r = lane_r[2:0];

   // Hit clearing acts on the pre-shift window; the shift (if any)
   // then operates on the cleared lane.
   always_comb begin
      run        = ((state == PLAY) || (state == FLUSH)) && !pause;
      hit_l_ok   = run && hit_l && (lane_l[2:0] != 3'b000);
      hit_r_ok   = run && hit_r && (lane_r[2:0] != 3'b000);
      lane_l_hit = lane_l;
      lane_r_hit = lane_r;
      if (hit_l_ok) lane_l_hit[2:0] = 3'b000;
      if (hit_r_ok) lane_r_hit[2:0] = 3'b000;
      tick_end   = (tick == TICK_LAST);
      note_l     = (state == PLAY) && rom_data[1];
      note_r     = (state == PLAY) && rom_data[0];
      gain       = {1'b0, hit_l_ok} + {1'b0, hit_r_ok};
      score_sum  = {1'b0, score} + (SCORE_W+1)'(gain);
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`ifdef MISS_COUNT_EN
      // A note still at bit 0 after clearing leaves the lane unscored.
      miss_gain  = {1'b0, lane_l_hit[0]} + {1'b0, lane_r_hit[0]};
      miss_sum   = {1'b0, misses} + (SCORE_W+1)'(miss_gain);
      miss_next  = miss_sum[SCORE_W] ? '1 : miss_sum[SCORE_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state     <= IDLE;
         rom_addr  <= '0;
         lane_l    <= '0;
         lane_r    <= '0;
         tick      <= '0;
         flush_cnt <= '0;
         score     <= '0;
`ifdef MISS_COUNT_EN
         misses    <= '0;
`endif
         step      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         step <= 1'b0;
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rom_addr  <= '0;
                  score     <= '0;
`ifdef MISS_COUNT_EN
                  misses    <= '0;
`endif
                  lane_l    <= '0;
                  lane_r    <= '0;
                  tick      <= '0;
                  flush_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (!pause) state <= PLAY;
            end
            PLAY, FLUSH: begin
               if (!pause) begin
                  score <= score_next;
                  if (tick_end) begin
                     tick   <= '0;
                     step   <= 1'b1;
                     lane_l <= {note_l, lane_l_hit[LANE_LEN-1:1]};
                     lane_r <= {note_r, lane_r_hit[LANE_LEN-1:1]};
`ifdef MISS_COUNT_EN
                     misses <= miss_next;
`endif
                     if (state == PLAY) begin
                        // Address holds on the last entry through FLUSH.
                        if (rom_addr == ADDR_LAST) begin
                           state     <= FLUSH;
                           flush_cnt <= '0;
                        end else begin
                           rom_addr <= rom_addr + 1'b1;
                        end
                     end else if (flush_cnt == FLUSH_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                     end
                  end else begin
                     tick   <= tick + 1'b1;
                     lane_l <= lane_l_hit;
                     lane_r <= lane_r_hit;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
